// File: rtl/controller.sv
// Multicycle control FSM: fetches an instruction word into IR, decodes it and
// sequences the datapath muxes and write strobes for each instruction class.
module controller #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_out,
  input  logic               mem_ready,
  input  logic [4:0]         flags,
  output logic [3:0]         opcode,
  output logic [3:0]         opext,
  output logic [REGBITS-1:0] rdest_addr,
  output logic [REGBITS-1:0] rsrc_addr,
  output logic [7:0]         imm,
  output logic               wa_s,
  output logic               pc_s,
  output logic               alub_s,
  output logic               mem_s,
  output logic               pcen,
  output logic               signext_sign,
  output logic               regwrite,
  output logic               memwrite,
  output logic               flagwrite,
  output logic               illegal,
  output logic [1:0]         wd_s,
  output logic [1:0]         alua_s
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StLoad, StStore, StBranch, StJump, StJal
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic        r_valid, cond;
  logic        flag_c, flag_l, flag_f, flag_z, flag_n;

  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = flags;

  assign opcode     = ir_q[15:12];
  assign opext      = ir_q[7:4];
  assign rdest_addr = REGBITS'(ir_q[11:8]);
  assign rsrc_addr  = REGBITS'(ir_q[3:0]);
  assign imm        = ir_q[7:0];
  assign illegal    = illegal_q;

  always_comb begin
    unique case (opext)
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
      4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101: r_valid = 1'b1;
      default:                                    r_valid = 1'b0;
    endcase
  end

  // Condition field lives in the Rdest slot for branches and jumps.
  always_comb begin
    unique case (ir_q[11:8])
      4'b0000: cond = flag_z;
      4'b0001: cond = !flag_z;
      4'b0010: cond = flag_c;
      4'b0011: cond = !flag_c;
      4'b0100: cond = flag_l;
      4'b0101: cond = !flag_l;
      4'b0110: cond = flag_n;
      4'b0111: cond = !flag_n;
      4'b1000: cond = flag_f;
      4'b1001: cond = !flag_f;
      4'b1010: cond = !flag_l && !flag_z;
      4'b1011: cond = flag_l || flag_z;
      4'b1100: cond = !flag_n && !flag_z;
      4'b1101: cond = flag_n || flag_z;
      4'b1110: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ir_d    = mem_out[15:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StFetch;
        case (opcode)
          4'b0000: if (r_valid) state_d = StExecR; else illegal_d = 1'b1;
          4'b0101, 4'b1101, 4'b1011: state_d = StExecI;
          4'b0100: begin
            case (opext)
              4'b0000: state_d = StLoad;
              4'b0100: state_d = StStore;
              4'b1100: state_d = StJump;
              4'b1000: state_d = StJal;
              default: illegal_d = 1'b1;
            endcase
          end
          4'b1100: state_d = StBranch;
          default: illegal_d = 1'b1;
        endcase
      end
      StLoad, StStore: if (mem_ready) state_d = StFetch;
      default:         state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    wa_s         = 1'b0;
    pc_s         = 1'b0;
    alub_s       = 1'b0;
    mem_s        = 1'b0;
    pcen         = 1'b0;
    signext_sign = 1'b0;
    regwrite     = 1'b0;
    memwrite     = 1'b0;
    flagwrite    = 1'b0;
    wd_s         = 2'b00;
    alua_s       = 2'b00;
    unique case (state_q)
      StFetch: begin
        alua_s = 2'b01;
        alub_s = 1'b1;
        pcen   = mem_ready;
      end
      StExecR, StExecI: begin
        alub_s       = (state_q == StExecI);
        wd_s         = 2'b11;
        wa_s         = 1'b1;
        flagwrite    = 1'b1;
        regwrite     = (opext != 4'b1011) && (opcode != 4'b1011);
        alua_s       = ((state_q == StExecR && opext == 4'b1101) || opcode == 4'b1101) ?
                       2'b10 : 2'b00;
        signext_sign = (state_q == StExecI) && (opcode != 4'b1101);
      end
      StLoad: begin
        mem_s    = 1'b1;
        regwrite = mem_ready;
        wa_s     = mem_ready;
      end
      StStore: begin
        mem_s    = 1'b1;
        memwrite = 1'b1;
      end
      StBranch: begin
        alua_s       = 2'b01;
        alub_s       = 1'b1;
        signext_sign = 1'b1;
        pcen         = cond;
      end
      StJump: begin
        pc_s = 1'b1;
        pcen = cond;
      end
      StJal: begin
        regwrite = 1'b1;
        wd_s     = 2'b01;
        wa_s     = 1'b1;
        pcen     = 1'b1;
        pc_s     = 1'b1;
      end
      default: ;
    endcase
    // Strobes stay quiet for as long as reset is held, whatever mem_ready does.
    if (!reset) begin
      pcen      = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      flagwrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed-vector bench for controller: walks each instruction class through the
// FSM and compares the packed control word against hand-derived values.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_out;
  logic        mem_ready;
  logic [4:0]  flags;
  logic [3:0]  opcode, opext, rdest_addr, rsrc_addr;
  logic [7:0]  imm;
  logic        wa_s, pc_s, alub_s, mem_s, pcen, signext_sign;
  logic        regwrite, memwrite, flagwrite, illegal;
  logic [1:0]  wd_s, alua_s;
  logic [13:0] ctl;

  int n_vec = 0;
  int n_err = 0;

  controller #(.WIDTH(16), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .mem_out(mem_out), .mem_ready(mem_ready), .flags(flags),
    .opcode(opcode), .opext(opext), .rdest_addr(rdest_addr), .rsrc_addr(rsrc_addr),
    .imm(imm), .wa_s(wa_s), .pc_s(pc_s), .alub_s(alub_s), .mem_s(mem_s), .pcen(pcen),
    .signext_sign(signext_sign), .regwrite(regwrite), .memwrite(memwrite),
    .flagwrite(flagwrite), .illegal(illegal), .wd_s(wd_s), .alua_s(alua_s)
  );

  always #5 clk = ~clk;

  assign ctl = {pcen, pc_s, regwrite, memwrite, flagwrite, illegal,
                wa_s, mem_s, alub_s, signext_sign, alua_s, wd_s};

  // Expected control word, argument order matches ctl.
  function automatic logic [13:0] mk(input logic pe, ps, rw, mw, fw, il, wa, ms, ab, sx,
                                     input logic [1:0] aa, wd);
    return {pe, ps, rw, mw, fw, il, wa, ms, ab, sx, aa, wd};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic [13:0] exp);
    @(negedge clk);
    check(tag, {2'b00, ctl}, {2'b00, exp});
  endtask

  // Called in FETCH just after an edge; returns in DECODE just after the next edge.
  task automatic run_fetch(input logic [15:0] word);
    mem_out   = word;
    mem_ready = 1'b1;
    next_cyc();
    mem_ready = 1'b0;
  endtask

  // Single-cycle instruction: fetch, decode, check the execute cycle, return to FETCH.
  task automatic exec_one(input string tag, input logic [15:0] word, input logic [13:0] exp);
    run_fetch(word);
    next_cyc();
    check_ctl(tag, exp);
    next_cyc();
  endtask

  localparam logic [13:0] FetchIdle = 14'b00_0000_0010_0100;

  logic [15:0] cw [11] = '{16'hC0FE, 16'hC0FE, 16'hCA00, 16'hCA00, 16'hCF00, 16'hCE00,
                           16'hCD00, 16'hC200, 16'hC600, 16'hC800, 16'hC500};
  logic [4:0]  cf [11] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b11111, 5'b00000,
                           5'b00001, 5'b10000, 5'b00000, 5'b00100, 5'b01000};
  logic        cp [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                           1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_out   = 16'h0355;
    flags     = 5'b0;
    next_cyc();
    next_cyc();
    check_ctl("rst ctl", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00));
    check("rst ir", {opcode, opext, rdest_addr, rsrc_addr}, 16'h0000);
    check("rst imm", {8'h00, imm}, 16'h0000);

    // ADD R3,R5 straight out of reset.
    next_cyc();
    reset = 1'b1;
    check_ctl("fetch", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00));
    next_cyc();
    mem_ready = 1'b0;
    check_ctl("dec ctl", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    check("dec fields", {opcode, opext, rdest_addr, rsrc_addr}, 16'h0535);
    next_cyc();
    check_ctl("add exec", mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b11));
    next_cyc();
    check_ctl("fetch hold", FetchIdle);
    next_cyc();
    check_ctl("fetch hold2", FetchIdle);

    // LOAD R3,(R0) with two wait cycles.
    run_fetch(16'h4300);
    next_cyc();
    check_ctl("ld wait1", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    check_ctl("ld wait2", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    mem_ready = 1'b1;
    check_ctl("ld done", mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    mem_ready = 1'b0;
    check_ctl("ld back", FetchIdle);
    next_cyc();

    // BEQ -2 taken and not taken.
    flags = 5'b00010;
    exec_one("beq taken", 16'hC0FE, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00));
    flags = 5'b00000;
    exec_one("beq not", 16'hC0FE, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b01, 2'b00));

    foreach (cw[i]) begin
      flags = cf[i];
      run_fetch(cw[i]);
      next_cyc();
      @(negedge clk);
      check($sformatf("cond %h/%b", cw[i], cf[i]), {15'b0, pcen}, {15'b0, cp[i]});
      next_cyc();
    end
    flags = 5'b00000;

    exec_one("jump uc", 16'h4EC7, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exec_one("jump never", 16'h4FC7, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exec_one("jal", 16'h4E87, mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01));
    exec_one("addi", 16'h5312, mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 2'b00, 2'b11));
    exec_one("movi", 16'hD3FF, mk(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 2'b10, 2'b11));
    exec_one("cmpi", 16'hB301, mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 2'b00, 2'b11));
    exec_one("cmp", 16'h03B4, mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b11));
    exec_one("mov", 16'h03D4, mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b10, 2'b11));

    // STORE: memwrite held through the wait and the ready cycle, gone after.
    run_fetch(16'h4347);
    next_cyc();
    check_ctl("st wait", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    mem_ready = 1'b1;
    check_ctl("st ready", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    mem_ready = 1'b0;
    check_ctl("st drop", FetchIdle);
    next_cyc();

    // Illegal opcode and illegal R-type extension.
    run_fetch(16'hF000);
    check_ctl("ill dec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    next_cyc();
    check_ctl("ill pulse", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b01, 2'b00));
    next_cyc();
    check_ctl("ill clear", FetchIdle);
    run_fetch(16'h03F4);
    next_cyc();
    check_ctl("ill opext", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b01, 2'b00));
    next_cyc();

    // Reset during the STORE wait.
    run_fetch(16'h4347);
    next_cyc();
    check_ctl("st pre rst", mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00));
    next_cyc();
    reset = 1'b0;
    next_cyc();
    check_ctl("rst st ctl", FetchIdle);
    check("rst st ir", {opcode, opext, rdest_addr, rsrc_addr}, 16'h0000);
    reset = 1'b1;
    exec_one("post rst add", 16'h0355, mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the instruction and data word width.
REQ-002 SHALL have parameter REGBITS, default 4, meaning the register-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port mem_out, input, WIDTH, memory read data; the instruction word is latched from it.
REQ-006 SHALL have port mem_ready, input, 1, memory access complete this cycle.
REQ-007 SHALL have port flags, input, 5, {C,L,F,Z,N} from the PSR.
REQ-008 SHALL have port opcode/opext, output, 4 each, IR[15:12] and IR[7:4], fed to alucontrol.
REQ-009 SHALL have port rdest_addr/rsrc_addr, output, REGBITS each, IR[11:8] and IR[3:0]; imm, output, 8, IR[7:0].
REQ-010 SHALL have ports wa_s, pc_s, alub_s, mem_s, pcen, signext_sign, regwrite, memwrite, flagwrite, illegal, output, 1 each; wd_s and alua_s, output, 2 each.

Function
REQ-011 SHALL implement an internal 16-bit IR that loads mem_out only in FETCH when mem_ready=1.
REQ-012 SHALL encode the muxes as follows: alua_s 00=Rdest, 01=PC, 10=zero; alub_s 0=Rsrc, 1=sign/zero-extended imm; wd_s 00=mem_out, 01=PC, 11=alu_out; wa_s 1=rdest_addr, 0=wa; mem_s 0=PC, 1=Rsrc; pc_s 0=alu_out, 1=Rsrc.
REQ-013 SHALL use the states FETCH, DECODE, EXEC_R, EXEC_I, LOAD, STORE, BRANCH, JUMP, and JAL. Outputs SHALL be Moore (state plus IR only), with each output 0 unless stated.
REQ-014 FETCH: mem_s=0, alua_s=01, alub_s=1, imm treated as +1. Hold while mem_ready=0. When mem_ready=1: pcen=1, pc_s=0, then go to DECODE.
REQ-015 DECODE SHALL branch as follows:
- opcode 0000 with a valid opext -> EXEC_R.
- 0101 (ADDI), 1101 (MOVI), 1011 (CMPI) -> EXEC_I.
- 0100 with opext 0000 -> LOAD; 0100 -> STORE; 1100 -> JUMP; 1000 -> JAL.
- 1100 -> BRANCH.
- anything else -> FETCH with illegal=1 for exactly one cycle.
REQ-016 EXEC_R (one cycle, then FETCH): alua_s=00, alub_s=0, wd_s=11, wa_s=1, flagwrite=1; regwrite=1 except CMP (opext 1011); MOV (opext 1101) uses alua_s=10.
REQ-017 EXEC_I: as EXEC_R but alub_s=1. signext_sign=1 for ADDI/CMPI and 0 for MOVI; MOVI uses alua_s=10.
REQ-018 LOAD: mem_s=1, hold until mem_ready, then regwrite=1, wd_s=00, wa_s=1 in the mem_ready cycle, then FETCH.
REQ-019 STORE: mem_s=1, memwrite=1 held until mem_ready=1, then FETCH; memwrite SHALL drop the cycle after mem_ready.
REQ-020 Condition (cond = rdest_addr):
- EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
- FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 1; 1111 never.
REQ-021 BRANCH: alua_s=01, alub_s=1, signext_sign=1, pc_s=0; pcen=cond. Then FETCH.
REQ-022 JUMP: pc_s=1, pcen=cond. Then FETCH.
REQ-023 JAL: cycle 1 regwrite=1, wd_s=01, wa_s=1 (link into Rdest), then pcen=1, pc_s=1 in the same cycle. Then FETCH.
REQ-024 flags SHALL be sampled in BRANCH/JUMP of the current instruction; a flagwrite in the immediately preceding instruction SHALL be visible.

Reset
REQ-025 reset=0 at any clock edge SHALL force FETCH, IR=0, and all outputs to 0 except mem_s=0, alua_s=01, alub_s=1 (the FETCH values), regardless of the current state, including mid-LOAD/STORE wait.
REQ-026 On release, the first FETCH SHALL occur in the cycle after reset returns to 1; no write strobe SHALL assert during or on the edge of release.

Verification
REQ-027 ADD R3,R5 (0x0355), mem_ready=1: FETCH->DECODE->EXEC_R with alua_s=00, alub_s=0, wd_s=11, wa_s=1, regwrite=1, opcode=0000, opext=0101; back to FETCH after 3 cycles.
REQ-028 LOAD with mem_ready low for 2 cycles: controller stays in LOAD with mem_s=1 and regwrite=0; regwrite=1 with wd_s=00 exactly in the mem_ready cycle.
REQ-029 BEQ disp=-2 (0xC0FE) with Z=1: pcen=1 in BRANCH and signext_sign=1; same word with Z=0: pcen=0.
REQ-030 JAL R14,R7 (0x4E87): regwrite=1, wd_s=01, pc_s=1, pcen=1 in a single cycle.
REQ-031 Opcode 0xF: illegal pulses one cycle after DECODE, with no regwrite or memwrite.
REQ-032 reset=0 asserted during the STORE wait: next cycle is FETCH with memwrite=0 and IR=0.
